// File: rtl/foc_frame_driver.sv
// Initiator for the FOC controller: loads d/q PID coefficients from shadow
// registers, then issues one saturated three-phase current frame per PWM period.
module foc_frame_driver #(
    parameter int unsigned D_WIDTH        = 19,
    parameter int unsigned Q_BITS         = 15,
    parameter int unsigned PERIOD_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      cfg_wen,
    input  logic [1:0]                cfg_sel,
    input  logic [D_WIDTH-1:0]        cfg_data,
    input  logic                      adc_valid,
    input  logic signed [D_WIDTH-1:0] adc_a,
    input  logic signed [D_WIDTH-1:0] adc_b,
    input  logic                      ready,
    output logic                      pid_d_wen,
    output logic                      pid_q_wen,
    output logic [D_WIDTH-1:0]        pid_d_addr,
    output logic [D_WIDTH-1:0]        pid_q_addr,
    output logic [D_WIDTH-1:0]        pid_d_data,
    output logic [D_WIDTH-1:0]        pid_q_data,
    output logic                      valid,
    output logic signed [D_WIDTH-1:0] currA_in,
    output logic signed [D_WIDTH-1:0] currB_in,
    output logic signed [D_WIDTH-1:0] currC_in,
    output logic                      busy,
    output logic                      err_timeout,
    output logic [7:0]                overrun_cnt
);

    localparam int unsigned PW = $clog2(PERIOD_CYCLES);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SW = D_WIDTH + 2;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] WCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [D_WIDTH-1:0] SMAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] SMIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_P   = 3'd1;
    localparam logic [2:0] LOAD_I   = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] ISSUE    = 3'd4;
    localparam logic [2:0] WAIT_RDY = 3'd5;

    if (Q_BITS >= D_WIDTH || PERIOD_CYCLES < 4) begin : g_bad_param
        $error("foc_frame_driver: Q_BITS must be below D_WIDTH and PERIOD_CYCLES at least 4");
    end

    logic [2:0]                state, state_nxt;
    logic [D_WIDTH-1:0]        kp_d, ki_d, kp_q, ki_q;
    logic signed [D_WIDTH-1:0] sample_a, sample_b;
    logic [PW-1:0]             pcnt, pcnt_nxt;
    logic [TW-1:0]             wcnt, wcnt_nxt;
    logic                      stop_pend, stop_nxt;
    logic                      reload_pend, reload_nxt;
    logic                      err_nxt;
    logic [7:0]                ovr_nxt;
    logic                      wen_nxt, valid_nxt, busy_nxt;
    logic [D_WIDTH-1:0]        addr_nxt, d_data_nxt, q_data_nxt;
    logic signed [D_WIDTH-1:0] curr_a_nxt, curr_b_nxt, curr_c_nxt;
    logic signed [SW-1:0]      neg_sum;
    logic signed [D_WIDTH-1:0] sat_c;
    logic                      tick;
    logic                      drop_state;

    // Host shadow copies of the PID coefficients
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            kp_d <= '0;
            ki_d <= '0;
            kp_q <= '0;
            ki_q <= '0;
        end else if (cfg_wen) begin
            case (cfg_sel)
                2'd0:    kp_d <= cfg_data;
                2'd1:    ki_d <= cfg_data;
                2'd2:    kp_q <= cfg_data;
                default: ki_q <= cfg_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sample_a <= '0;
            sample_b <= '0;
        end else if (adc_valid) begin
            sample_a <= adc_a;
            sample_b <= adc_b;
        end
    end

    // Phase C = -(A+B); two guard bits so negating the most negative sum cannot wrap
    assign neg_sum = -(SW'(sample_a) + SW'(sample_b));

    always_comb begin
        sat_c = neg_sum[D_WIDTH-1:0];
        if (neg_sum[SW-1:D_WIDTH-1] != 3'b000 && neg_sum[SW-1:D_WIDTH-1] != 3'b111) begin
            sat_c = neg_sum[SW-1] ? SMIN : SMAX;
        end
    end

    assign tick       = (pcnt == PCNT_LAST);
    assign drop_state = (state == LOAD_P) || (state == LOAD_I) ||
                        (state == ISSUE)  || (state == WAIT_RDY);

    always_comb begin
        state_nxt  = state;
        stop_nxt   = stop_pend;
        reload_nxt = reload_pend;
        err_nxt    = err_timeout;
        ovr_nxt    = overrun_cnt;
        wcnt_nxt   = wcnt;
        pcnt_nxt   = '0;
        wen_nxt    = 1'b0;
        addr_nxt   = '0;
        d_data_nxt = '0;
        q_data_nxt = '0;
        valid_nxt  = 1'b0;
        curr_a_nxt = currA_in;
        curr_b_nxt = currB_in;
        curr_c_nxt = currC_in;

        if (state != IDLE) begin
            pcnt_nxt = tick ? '0 : pcnt + PW'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_P;
                    err_nxt   = 1'b0;
                    ovr_nxt   = '0;
                end
            end
            LOAD_P: state_nxt = LOAD_I;
            LOAD_I: state_nxt = RUN;
            RUN: begin
                if (stop_pend) begin
                    state_nxt = IDLE;
                end else if (reload_pend) begin
                    state_nxt = LOAD_P;
                end else if (tick) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_nxt  = wcnt + TW'(1);
                state_nxt = ready ? RUN : WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready) begin
                    state_nxt = RUN;
                end else if (wcnt == WCNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    wcnt_nxt = wcnt + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (tick && drop_state && overrun_cnt != 8'hFF) begin
            ovr_nxt = overrun_cnt + 8'd1;
        end

        // A write landing during LOAD_I must still trigger another reload
        if (state == LOAD_I) begin
            reload_nxt = 1'b0;
        end
        if (cfg_wen && state != IDLE) begin
            reload_nxt = 1'b1;
        end

        if (stop) begin
            stop_nxt = 1'b1;
        end
        if (state_nxt == IDLE) begin
            stop_nxt = 1'b0;
        end

        // Outputs are registered against the state being entered
        case (state_nxt)
            LOAD_P: begin
                wen_nxt    = 1'b1;
                d_data_nxt = kp_d;
                q_data_nxt = kp_q;
            end
            LOAD_I: begin
                wen_nxt    = 1'b1;
                addr_nxt   = D_WIDTH'(1);
                d_data_nxt = ki_d;
                q_data_nxt = ki_q;
            end
            ISSUE: begin
                valid_nxt  = 1'b1;
                curr_a_nxt = sample_a;
                curr_b_nxt = sample_b;
                curr_c_nxt = sat_c;
                wcnt_nxt   = '0;
            end
            default: ;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            pcnt        <= '0;
            wcnt        <= '0;
            stop_pend   <= 1'b0;
            reload_pend <= 1'b0;
            pid_d_wen   <= 1'b0;
            pid_q_wen   <= 1'b0;
            pid_d_addr  <= '0;
            pid_q_addr  <= '0;
            pid_d_data  <= '0;
            pid_q_data  <= '0;
            valid       <= 1'b0;
            currA_in    <= '0;
            currB_in    <= '0;
            currC_in    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state       <= state_nxt;
            pcnt        <= pcnt_nxt;
            wcnt        <= wcnt_nxt;
            stop_pend   <= stop_nxt;
            reload_pend <= reload_nxt;
            pid_d_wen   <= wen_nxt;
            pid_q_wen   <= wen_nxt;
            pid_d_addr  <= addr_nxt;
            pid_q_addr  <= addr_nxt;
            pid_d_data  <= d_data_nxt;
            pid_q_data  <= q_data_nxt;
            valid       <= valid_nxt;
            currA_in    <= curr_a_nxt;
            currB_in    <= curr_b_nxt;
            currC_in    <= curr_c_nxt;
            busy        <= busy_nxt;
            err_timeout <= err_nxt;
            overrun_cnt <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_foc_frame_driver.sv
// Directed bench for foc_frame_driver: coefficient load, frame currents and
// saturation, timeout, reload, stop, async reset and overrun counting.
module tb_foc_frame_driver;

    localparam int unsigned DW = 19;

    logic clk = 1'b0;
    logic rstb, start, stop, cfg_wen, adc_valid, ready, ready_2;
    logic [1:0] cfg_sel;
    logic [DW-1:0] cfg_data;
    logic signed [DW-1:0] adc_a, adc_b;

    logic pid_d_wen, pid_q_wen, valid, busy, err_timeout;
    logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
    logic signed [DW-1:0] currA_in, currB_in, currC_in;
    logic [7:0] overrun_cnt;

    logic pid_d_wen_2, pid_q_wen_2, valid_2, busy_2, err_timeout_2;
    logic [DW-1:0] pid_d_addr_2, pid_q_addr_2, pid_d_data_2, pid_q_data_2;
    logic signed [DW-1:0] currA_in_2, currB_in_2, currC_in_2;
    logic [7:0] overrun_cnt_2;

    foc_frame_driver #(.D_WIDTH(DW), .Q_BITS(15), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .rstb(rstb), .start(start), .stop(stop),
        .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .adc_valid(adc_valid), .adc_a(adc_a), .adc_b(adc_b), .ready(ready),
        .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
        .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
        .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
        .valid(valid), .currA_in(currA_in), .currB_in(currB_in), .currC_in(currC_in),
        .busy(busy), .err_timeout(err_timeout), .overrun_cnt(overrun_cnt)
    );

    // Long timeout instance so late ready produces overruns instead of timeouts
    foc_frame_driver #(.D_WIDTH(DW), .Q_BITS(15), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(64)) u_ovr (
        .clk(clk), .rstb(rstb), .start(start), .stop(stop),
        .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .adc_valid(adc_valid), .adc_a(adc_a), .adc_b(adc_b), .ready(ready_2),
        .pid_d_wen(pid_d_wen_2), .pid_q_wen(pid_q_wen_2),
        .pid_d_addr(pid_d_addr_2), .pid_q_addr(pid_q_addr_2),
        .pid_d_data(pid_d_data_2), .pid_q_data(pid_q_data_2),
        .valid(valid_2), .currA_in(currA_in_2), .currB_in(currB_in_2), .currC_in(currC_in_2),
        .busy(busy_2), .err_timeout(err_timeout_2), .overrun_cnt(overrun_cnt_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int a;
        int b;
        int ea;
        int eb;
        int ec;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input int data);
        cfg_wen  = 1'b1;
        cfg_sel  = sel;
        cfg_data = DW'(data);
        step();
        cfg_wen  = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output bit seen, output int at);
        int i;
        seen = 1'b0;
        at   = 0;
        i    = 0;
        while (!seen && i < 60) begin
            if ((sel ? valid_2 : valid) == 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end else begin
                step();
                i++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int v, v_prev, v0, v1, v2, v3, t_load;

        vecs[0] = '{a:  16384, b: -16384, ea:  16384, eb: -16384, ec:       0};
        vecs[1] = '{a:-262144, b:-262144, ea:-262144, eb:-262144, ec:  262143};
        vecs[2] = '{a: 131072, b: 131072, ea: 131072, eb: 131072, ec: -262144};
        vecs[3] = '{a:   1000, b:   2000, ea:   1000, eb:   2000, ec:   -3000};
        vecs[4] = '{a: 262143, b: 262143, ea: 262143, eb: 262143, ec: -262144};
        vecs[5] = '{a:     -1, b:      0, ea:     -1, eb:      0, ec:       1};

        rstb = 1'b0; start = 1'b0; stop = 1'b0; cfg_wen = 1'b0; cfg_sel = '0;
        cfg_data = '0; adc_valid = 1'b0; adc_a = '0; adc_b = '0;
        ready = 1'b0; ready_2 = 1'b0;
        step(3);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_d_wen", int'(pid_d_wen), 0);
        check("rst_q_wen", int'(pid_q_wen), 0);
        check("rst_err", int'(err_timeout), 0);
        check("rst_overrun", int'(overrun_cnt), 0);
        check("rst_currC", int'(currC_in), 0);
        rstb = 1'b1;
        step();

        cfg_write(2'd0, 4096);
        cfg_write(2'd1, 512);
        cfg_write(2'd2, 4096);
        cfg_write(2'd3, 512);
        check("idle_busy", int'(busy), 0);

        // Coefficient load sequence
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_p_d_wen", int'(pid_d_wen), 1);
        check("load_p_q_wen", int'(pid_q_wen), 1);
        check("load_p_d_addr", int'(pid_d_addr), 0);
        check("load_p_q_addr", int'(pid_q_addr), 0);
        check("load_p_d_data", int'(pid_d_data), 4096);
        check("load_p_q_data", int'(pid_q_data), 4096);
        check("load_busy", int'(busy), 1);
        step();
        check("load_i_d_addr", int'(pid_d_addr), 1);
        check("load_i_q_addr", int'(pid_q_addr), 1);
        check("load_i_d_data", int'(pid_d_data), 512);
        check("load_i_q_data", int'(pid_q_data), 512);
        step();
        check("run_d_wen", int'(pid_d_wen), 0);
        check("run_q_wen", int'(pid_q_wen), 0);
        check("run_q_data", int'(pid_q_data), 0);

        // Frame table; the next sample is presented during ISSUE
        adc_a = DW'(vecs[0].a);
        adc_b = DW'(vecs[0].b);
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        v_prev = 0;
        for (int i = 0; i < 6; i++) begin
            wait_valid(1'b0, seen, v);
            check($sformatf("frame%0d_valid_seen", i), int'(seen), 1);
            check($sformatf("frame%0d_currA", i), int'(currA_in), vecs[i].ea);
            check($sformatf("frame%0d_currB", i), int'(currB_in), vecs[i].eb);
            check($sformatf("frame%0d_currC", i), int'(currC_in), vecs[i].ec);
            if (i > 0) check($sformatf("frame%0d_period", i), v - v_prev, 20);
            v_prev = v;
            if (i < 5) begin
                adc_a = DW'(vecs[i+1].a);
                adc_b = DW'(vecs[i+1].b);
                adc_valid = 1'b1;
            end
            step();
            adc_valid = 1'b0;
            check($sformatf("frame%0d_valid_pulse", i), int'(valid), 0);
            check($sformatf("frame%0d_currC_held", i), int'(currC_in), vecs[i].ec);
            step(4);
            ready = 1'b1;
            step();
            ready = 1'b0;
        end
        check("frames_overrun", int'(overrun_cnt), 0);
        check("frames_err", int'(err_timeout), 0);

        // Timeout: ready withheld
        wait_valid(1'b0, seen, v0);
        check("to_valid_seen", int'(seen), 1);
        step(7);
        check("to_err_before", int'(err_timeout), 0);
        step();
        check("to_err_rise", int'(err_timeout), 1);
        wait_valid(1'b0, seen, v1);
        check("to_next_frame_seen", int'(seen), 1);
        check("to_next_frame_period", v1 - v0, 20);
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_start_busy_err_kept", int'(err_timeout), 1);
        check("to_start_busy_still_busy", int'(busy), 1);

        // Reload triggered by a mid-run write
        wait_valid(1'b0, seen, v2);
        check("rl_valid_seen", int'(seen), 1);
        step(2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        step(2);
        cfg_write(2'd2, 2048);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (pid_q_wen || valid) seen = 1'b1;
            else step();
        end
        t_load = cyc;
        check("rl_q_wen", int'(pid_q_wen), 1);
        check("rl_before_valid", int'(valid), 0);
        check("rl_latency", t_load - v2, 7);
        check("rl_p_q_addr", int'(pid_q_addr), 0);
        check("rl_p_q_data", int'(pid_q_data), 2048);
        check("rl_p_d_data", int'(pid_d_data), 4096);
        step();
        check("rl_i_q_addr", int'(pid_q_addr), 1);
        check("rl_i_q_data", int'(pid_q_data), 512);
        wait_valid(1'b0, seen, v3);
        check("rl_next_valid_seen", int'(seen), 1);
        check("rl_next_valid_period", v3 - v2, 20);

        // Stop while waiting: only honoured after ready
        step(2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step(2);
        check("stop_waits_ready", int'(busy), 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("stop_run_busy", int'(busy), 1);
        step();
        check("stop_busy_fall", int'(busy), 0);
        check("stop_no_valid", int'(valid), 0);

        // Asynchronous reset during load and during a frame
        start = 1'b1;
        step();
        start = 1'b0;
        check("ar_load_wen_before", int'(pid_d_wen), 1);
        rstb = 1'b0;
        #1;
        check("ar_load_wen", int'(pid_d_wen), 0);
        check("ar_load_busy", int'(busy), 0);
        step(2);
        rstb = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(1'b0, seen, v);
        check("ar_valid_seen", int'(seen), 1);
        rstb = 1'b0;
        #1;
        check("ar_frame_valid", int'(valid), 0);
        step(2);
        rstb = 1'b1;
        step();

        // Overrun: ready returned 30 cycles after each frame
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            wait_valid(1'b1, seen, v);
            check($sformatf("ovr%0d_valid_seen", k), int'(seen), 1);
            step(30);
            ready_2 = 1'b1;
            step();
            ready_2 = 1'b0;
            check($sformatf("ovr%0d_count", k), int'(overrun_cnt_2), k);
        end
        check("timeout_no_overrun", int'(overrun_cnt), 0);
        check("timeout_err_sticky", int'(err_timeout), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
